// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between two 32-bit word requesters (0 = CPU/APB, 1 = GPIO).
//   Requesters are granted round-robin. Each granted word is sent as NUM_BYTES bytes, LSB first,
//   using the txStart/txDone handshake. The owner then gets a one-cycle ack.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to abort a byte that sees no txDone within
// TIMEOUT_CYCLES WAIT_DONE cycles. An aborted word acks with err=1 and drops its remaining bytes.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req0/req1         level requests
//   data0/data1       words, sampled only at grant
//   ack0/ack1         1-cycle done/abort pulse to the owner
//   busy              UART busy, blocks new grants in IDLE only
//   txDone            UART finished the current byte (pulse)
//   txStart, txData   start pulse and byte; txData held until txDone
//   tx_en, owner      high and owner index while a word is owned
//   err               pulses with ack when the word was aborted on timeout
module uart_tx_arbiter #(
  parameter int unsigned NUM_BYTES      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        ack1,
  input  logic        busy,
  input  logic        txDone,
  output logic        txStart,
  output logic [7:0]  txData,
  output logic        tx_en,
  output logic        owner,
  output logic        err
);

  localparam logic [1:0] LastByte = 2'(NUM_BYTES - 1);

  if (NUM_BYTES < 1 || NUM_BYTES > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536)
  begin : g_param_check
    $error("uart_tx_arbiter: NUM_BYTES or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {StIdle, StStart, StWaitDone, StAck} state_e;

  state_e      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        owner_q, owner_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        err_q, err_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        win;
  logic [31:0] win_data;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] WaitLimit = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    owner_d    = owner_q;
    tx_en_d    = tx_en_q;
    tx_data_d  = tx_data_q;
    rr_ptr_d   = rr_ptr_q;
    // Pulse outputs fall back to 0 unless set below.
    tx_start_d = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err_d      = 1'b0;
    // The round-robin pointer only matters when both requesters ask at once.
    win        = (req0 && req1) ? rr_ptr_q : req1;
    win_data   = win ? data1 : data0;
`ifdef UART_ARB_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        tx_en_d = 1'b0;
        if ((req0 || req1) && !busy) begin
          shift_d    = win_data;
          byte_cnt_d = 2'd0;
          owner_d    = win;
          tx_en_d    = 1'b1;
          tx_data_d  = win_data[7:0];
          tx_start_d = 1'b1;
          state_d    = StStart;
        end
      end
      StStart: begin
        state_d = StWaitDone;
`ifdef UART_ARB_TIMEOUT_EN
        wait_cnt_d = 16'd0;
`endif
      end
      StWaitDone: begin
        if (txDone) begin
          if (byte_cnt_q == LastByte) begin
            ack0_d  = ~owner_q;
            ack1_d  = owner_q;
            state_d = StAck;
          end else begin
            shift_d    = shift_q >> 8;
            byte_cnt_d = byte_cnt_q + 2'd1;
            tx_data_d  = shift_q[15:8];
            tx_start_d = 1'b1;
            state_d    = StStart;
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (wait_cnt_q == WaitLimit) begin
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          err_d   = 1'b1;
          state_d = StAck;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
`endif
      end
      StAck: begin
        rr_ptr_d = ~owner_q;
        tx_en_d  = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= 32'd0;
      byte_cnt_q <= 2'd0;
      owner_q    <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_start_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
      rr_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      owner_q    <= owner_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err_q      <= err_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= 16'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  assign txStart = tx_start_q;
  assign txData  = tx_data_q;
  assign tx_en   = tx_en_q;
  assign owner   = owner_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign err     = err_q;

endmodule
